// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, default datapath width and the bit layout
// of the status flags stored alongside each buffered result.
package alu_pkg;

   localparam int WIDTH_DEFAULT = 4;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD = 3'd0;
   localparam op_t OP_SUB = 3'd1;
   localparam op_t OP_AND = 3'd2;
   localparam op_t OP_OR  = 3'd3;
   localparam op_t OP_SHL = 3'd4;

   // Flag positions inside the packed {result, flags} buffer entry.
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_LOST  = 1;
   localparam int FLAG_RANGE = 2;
   localparam int NUM_FLAGS  = 3;

endpackage

// File: rtl/alu_result_stage_if.sv
// Producer-side and consumer-side handshake bundle of the ALU result stage.
// The master modport is the environment (ALU + writeback), slave is the stage.
interface alu_result_stage_if
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   op_t              in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_result;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_lost;
   logic             out_range;
   logic [CW-1:0]    occupancy;

   modport master (
      output in_valid, in_op, in_a, in_b, in_result, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_lost, out_range, occupancy
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_result, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_lost, out_range, occupancy
   );

endinterface

// File: rtl/result_fifo.sv
// Generic first-word-fall-through FIFO with an occupancy count; head data is
// visible combinationally so a pushed entry is presented one edge after push.
module result_fifo #(
   parameter int DW    = 7,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic [CW-1:0] count
);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          push_ok;
   logic          pop_ok;

   // Overflow pushes and underflow pops are dropped without touching state.
   assign push_ok = push && (count_reg != CW'(DEPTH));
   assign pop_ok  = pop && (count_reg != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push_ok && !pop_ok)
            count_reg <= count_reg + CW'(1);
         else if (pop_ok && !push_ok)
            count_reg <= count_reg - CW'(1);
      end
   end

   // Storage carries no reset; stale contents are masked by the count.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= din;
   end

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: derives zero/lost/range flags at push
// time and buffers {result, flags} so the consumer may stall.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_result_stage_if.slave bus
);
   localparam int DW = WIDTH + NUM_FLAGS;
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 rdy_en_reg;
   logic [CW-1:0]        count;
   logic [DW-1:0]        head;
   logic [NUM_FLAGS-1:0] flags;
   logic [WIDTH-1:0]     lost_bits;
   logic                 is_shl;
   logic                 push;
   logic                 pop;

   // Holds in_ready low while reset is asserted and until the first edge after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en_reg <= 1'b0;
      else        rdy_en_reg <= 1'b1;
   end

   assign is_shl = (bus.in_op == OP_SHL);

   // Bit gi of A leaves the word when gi + b >= WIDTH; b >= WIDTH loses every bit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lost
      assign lost_bits[gi] = bus.in_a[gi] & ({1'b0, bus.in_b} >= (WIDTH+1)'(WIDTH - gi));
   end

   assign flags[FLAG_ZERO]  = (bus.in_result == '0);
   assign flags[FLAG_RANGE] = is_shl && ({1'b0, bus.in_b} >= (WIDTH+1)'(WIDTH));
   assign flags[FLAG_LOST]  = is_shl && (|lost_bits);

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   result_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({bus.in_result, flags}),
      .dout  (head),
      .count (count)
   );

   assign bus.in_ready   = rdy_en_reg && (count < CW'(DEPTH));
   assign bus.out_valid  = (count != '0);
   assign bus.occupancy  = count;
   assign bus.out_result = bus.out_valid ? head[DW-1:NUM_FLAGS] : '0;
   assign bus.out_zero   = bus.out_valid & head[FLAG_ZERO];
   assign bus.out_lost   = bus.out_valid & head[FLAG_LOST];
   assign bus.out_range  = bus.out_valid & head[FLAG_RANGE];

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, flag vectors, backpressure and
// full-throughput streaming with hand-computed expectations.
module tb_alu_result_stage;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_result_stage_if #(.WIDTH(4), .DEPTH(2)) bus();

   alu_result_stage #(.WIDTH(4), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // {in_ready, out_valid, occupancy[1:0], out_result[3:0], zero, lost, range}
   logic [10:0] snap;
   assign snap = {bus.in_ready, bus.out_valid, bus.occupancy, bus.out_result,
                  bus.out_zero, bus.out_lost, bus.out_range};

   localparam logic [10:0] IDLE = {1'b1, 1'b0, 2'd0, 4'd0, 3'b000};

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] r;
      logic       z;
      logic       l;
      logic       g;
   } vec_t;

   vec_t tbl [9] = '{
      '{OP_SHL, 4'b1011, 4'd1,    4'b0110, 1'b0, 1'b1, 1'b0},
      '{OP_SHL, 4'b0011, 4'd2,    4'b1100, 1'b0, 1'b0, 1'b0},
      '{OP_SHL, 4'b0001, 4'd5,    4'b0000, 1'b1, 1'b1, 1'b1},
      '{OP_SHL, 4'b0000, 4'd9,    4'b0000, 1'b1, 1'b0, 1'b1},
      '{OP_AND, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0},
      '{OP_ADD, 4'b1111, 4'b1111, 4'b1110, 1'b0, 1'b0, 1'b0},
      '{OP_SHL, 4'b1000, 4'd0,    4'b1000, 1'b0, 1'b0, 1'b0},
      '{OP_SHL, 4'b0100, 4'd4,    4'b0000, 1'b1, 1'b1, 1'b1},
      '{OP_SHL, 4'b0100, 4'd3,    4'b0000, 1'b1, 1'b1, 1'b0}
   };

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_op     = OP_ADD;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_result = '0;
      bus.out_ready = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [10:0] exp;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      vectors++;
      if (snap !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_initial: got %h expected %h", snap, 11'd0);
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready_before_edge: got %b expected 0", bus.in_ready);
      end
      step();
      vectors++;
      if (snap !== IDLE) begin
         miscompares++;
         $display("FAIL reset_release: got %h expected %h", snap, IDLE);
      end
      // Fill two entries, then assert reset mid-cycle.
      bus.in_valid = 1'b1; bus.in_result = 4'd5;
      step();
      bus.in_result = 4'd6;
      step();
      bus.in_valid = 1'b0;
      exp = {1'b0, 1'b1, 2'd2, 4'd5, 3'b000};
      vectors++;
      if (snap !== exp) begin
         miscompares++;
         $display("FAIL reset_prefill: got %h expected %h", snap, exp);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (snap !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_async_clear: got %h expected %h", snap, 11'd0);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      vectors++;
      if (snap !== IDLE) begin
         miscompares++;
         $display("FAIL reset_no_stale: got %h expected %h", snap, IDLE);
      end
      $display("reset: snap=%h", snap);
   endtask

   task automatic test_flags();
      logic [10:0] exp;
      for (int i = 0; i < 9; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_op     = tbl[i].op;
         bus.in_a      = tbl[i].a;
         bus.in_b      = tbl[i].b;
         bus.in_result = tbl[i].r;
         bus.out_ready = 1'b0;
         #3;
         vectors++;
         if (snap !== IDLE) begin
            miscompares++;
            $display("FAIL flags%0d_no_bypass: got %h expected %h", i, snap, IDLE);
         end
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         exp = {1'b1, 1'b1, 2'd1, tbl[i].r, tbl[i].z, tbl[i].l, tbl[i].g};
         vectors++;
         if (snap !== exp) begin
            miscompares++;
            $display("FAIL flags%0d_head: got %h expected %h", i, snap, exp);
         end
         $display("flags %0d: op=%0d a=%b b=%0d r=%b -> z=%b l=%b g=%b", i, tbl[i].op,
                  tbl[i].a, tbl[i].b, tbl[i].r, bus.out_zero, bus.out_lost, bus.out_range);
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'b0;
         vectors++;
         if (snap !== IDLE) begin
            miscompares++;
            $display("FAIL flags%0d_drain: got %h expected %h", i, snap, IDLE);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] exp;
      idle_inputs();
      bus.in_valid = 1'b1; bus.in_result = 4'd1;
      step();
      exp = {1'b1, 1'b1, 2'd1, 4'd1, 3'b000};
      vectors++;
      if (snap !== exp) begin
         miscompares++;
         $display("FAIL bp_push1: got %h expected %h", snap, exp);
      end
      bus.in_result = 4'd2;
      step();
      exp = {1'b0, 1'b1, 2'd2, 4'd1, 3'b000};
      vectors++;
      if (snap !== exp) begin
         miscompares++;
         $display("FAIL bp_push2_full: got %h expected %h", snap, exp);
      end
      bus.in_result = 4'd3;
      step();
      vectors++;
      if (snap !== exp) begin
         miscompares++;
         $display("FAIL bp_push3_dropped: got %h expected %h", snap, exp);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_ready_no_comb: got %b expected 0", bus.in_ready);
      end
      step();
      exp = {1'b1, 1'b1, 2'd1, 4'd2, 3'b000};
      vectors++;
      if (snap !== exp) begin
         miscompares++;
         $display("FAIL bp_pop1: got %h expected %h", snap, exp);
      end
      step();
      vectors++;
      if (snap !== IDLE) begin
         miscompares++;
         $display("FAIL bp_pop2_empty: got %h expected %h", snap, IDLE);
      end
      bus.out_ready = 1'b0;
      $display("backpressure: drained, snap=%h", snap);
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp;
      idle_inputs();
      // Push and pop together while empty: only the push takes effect.
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_result = 4'd15;
      step();
      exp = {1'b1, 1'b1, 2'd1, 4'd15, 3'b000};
      vectors++;
      if (snap !== exp) begin
         miscompares++;
         $display("FAIL b2b_empty_pushpop: got %h expected %h", snap, exp);
      end
      for (int k = 1; k <= 8; k++) begin
         bus.in_result = 4'(k);
         step();
         exp = {1'b1, 1'b1, 2'd1, 4'(k), 3'b000};
         vectors++;
         if (snap !== exp) begin
            miscompares++;
            $display("FAIL b2b_stream%0d: got %h expected %h", k, snap, exp);
         end
         $display("stream %0d: head=%0d occ=%0d", k, bus.out_result, bus.occupancy);
      end
      bus.in_valid = 1'b0;
      step();
      vectors++;
      if (snap !== IDLE) begin
         miscompares++;
         $display("FAIL b2b_final_drain: got %h expected %h", snap, IDLE);
      end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_flags();
      test_backpressure();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
